conv_seq_ctrl: RTL and testbench
================================

Name: conv_seq_ctrl

Overview:
- Sequencing controller for the 8-tap-input / 4-tap-filter convolution datapath: x memory, f memory, 4-lane multiply/sum accumulator and y output register.
- Runs three phases in order: load N x samples and M filter taps over valid/ready, issue windowed reads, then present N-M+1 outputs one at a time on m_valid_y/m_ready_y.
- Owns every memory address, write enable and accumulator control, so the datapath holds no control logic.

Parameters:
- N, 8, x vector length.
- M, 4, filter length; must satisfy M <= N and M % LANES == 0 (elaboration $error otherwise).
- LANES, 4, taps read per memory access (memory read width).
- LOGN, 3, x address width, clog2(N).
- LOGM, 2, f address width, clog2(M).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- s_valid_x  in  1  x sample offered.
- s_ready_x  out  1  x sample accepted when high with s_valid_x.
- s_valid_f  in  1  filter tap offered.
- s_ready_f  out  1  tap accepted when high with s_valid_f.
- m_valid_y  out  1  y result valid.
- m_ready_y  in  1  downstream accepts y.
- addr_x  out  LOGN  x memory address (write address in LOAD, read base otherwise).
- wr_en_x  out  1  x memory write enable.
- addr_f  out  LOGM  f memory address.
- wr_en_f  out  1  f memory write enable.
- clr_acc  out  1  zero the accumulator at the next edge.
- en_acc  out  1  add the lane sum into the accumulator at the next edge.

Behaviour:
- Memory read latency is 1 cycle. Accumulator rule in the datapath: clr_acc has priority, then en_acc, then hold.
- Reset values: state LOAD, x_cnt=0, f_cnt=0, out_idx=0, tap=0. m_valid_y=0, clr_acc=0, en_acc=0.
- While reset is high, s_ready_x, s_ready_f, wr_en_x and wr_en_f are combinationally 0.
- Reset mid-operation abandons the current vector completely. No partial output is presented afterwards.
- LOAD state:
  - s_ready_x = (x_cnt < N); s_ready_f = (f_cnt < M).
  - wr_en_x = s_valid_x & s_ready_x, with addr_x = x_cnt. wr_en_f works the same way with addr_f = f_cnt.
  - The x and f streams are independent and may be accepted in the same cycle.
  - Data arriving when valid is low is ignored and may be X.
  - When x_cnt==N and f_cnt==M, go to ISSUE with out_idx=0 and tap=0. The final x and final f accepted on the same edge must also work.
- ISSUE state (K = M/LANES cycles per output):
  - addr_x = out_idx + tap, addr_f = tap. tap increments by LANES each cycle.
  - clr_acc=1 on the tap==0 cycle only.
  - After the tap==M-LANES cycle, go to DRAIN.
- en_acc is a register: high exactly in the cycle after each ISSUE cycle (ISSUE cycles 2..K plus DRAIN).
- DRAIN state: 1 cycle for the final accumulate, then go to OUT.
- OUT state:
  - m_valid_y=1, held stable until m_ready_y.
  - No new reads are issued and en_acc=0.
  - On handshake with out_idx < N-M: out_idx++, tap=0, go to ISSUE.
  - On handshake with out_idx == N-M: clear x_cnt/f_cnt/out_idx, go to LOAD. m_valid_y is 0 the next cycle.
- s_ready_x and s_ready_f are 0 in every state except LOAD. The next vector is not preloaded.
- Timing, default parameters:
  - m_valid_y rises 2 edges after the edge accepting the final input.
  - Minimum spacing between outputs is K+2 cycles.
  - Minimum total per vector is N+... (load-limited) + (N-M+1)*(K+2) cycles.
- Address arithmetic: out_idx+tap never exceeds N-LANES, so addr_x never wraps. tap is LOGM+1 bits wide to hold M without overflow.
- Output widths are fixed. No arithmetic happens in this block beyond the counters.

Decomposition:
- conv_pkg holds:
  - typedef enum logic [1:0] {LOAD, ISSUE, DRAIN, OUT} conv_state_t;
  - localparam CONV_LANES = 4;
  - function clog2-based width helper.
- One sub-module, load_cnt #(SIZE, LOGSIZE), instantiated for x and for f.
  - Ports: clk, reset, valid, ready, wr_en, cnt, full, clear.
  - It generates ready, wr_en and the write count for one stream.

Test Plan:
- Reset, then x=1..8 and f=1,1,1,1 with valid and ready always high: outputs 10,14,18,22,26. m_valid_y rises 2 cycles after the last input; outputs are spaced 3 cycles apart.
- f fully loaded first, x gaps with valid toggling 1/0, X data on idle cycles: wr_en_x fires only on handshakes. s_ready_f stays 0 after 4 taps. Results are unchanged.
- m_ready_y held low 10 cycles on output 2: m_valid_y stays high, en_acc=0 and addr_x is frozen throughout. The next output begins ISSUE on the cycle after the handshake.
- Final x and final f accepted on the same edge: ISSUE entered on the next cycle. clr_acc=1 for exactly that one cycle and addr_x=0.
- Reset asserted while in OUT on output 3: the next cycle shows m_valid_y=0, s_ready_x=1 and s_ready_f=1. A fresh vector x=-128 ×8, f=127 ×4 yields -65024 five times.
- Parameter check N=16, M=8 (LANES 4): K=2. clr_acc appears on first ISSUE cycles only and en_acc pulses twice per output. Nine outputs match a software reference.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution sequencing controller.
package conv_pkg;

   typedef enum logic [1:0] {LOAD, ISSUE, DRAIN, OUT} conv_state_t;

   localparam int CONV_LANES = 4;

   function automatic int conv_width(input int depth);
      return (depth <= 1) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/conv_seq_ctrl_load_cnt.sv
// Write counter for one input stream: owns ready, the write strobe and the write address.
module load_cnt #(
   parameter int SIZE    = 8,
   parameter int LOGSIZE = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               valid,
   output logic               ready,
   output logic               wr_en,
   output logic [LOGSIZE:0]   cnt,
   output logic               full,
   input  logic               clear
);

   assign full  = (cnt == (LOGSIZE+1)'(SIZE));
   assign ready = ~reset & ~full;
   assign wr_en = valid & ready;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         cnt <= '0;
      end else if (wr_en) begin
         cnt <= cnt + (LOGSIZE+1)'(1);
      end
   end

endmodule

// File: rtl/conv_seq_ctrl.sv
// Sequencer for the x/f memories and lane accumulator: load, windowed issue, drain, output.
//
// state | meaning
// LOAD  | accept x samples and filter taps into memory
// ISSUE | read one LANES-wide slice of window and taps per cycle
// DRAIN | final accumulate of the last slice read
// OUT   | y valid, waiting for downstream handshake
module conv_seq_ctrl
   import conv_pkg::*;
#(
   parameter int N     = 8,
   parameter int M     = 4,
   parameter int LANES = CONV_LANES,
   parameter int LOGN  = conv_width(N),
   parameter int LOGM  = conv_width(M)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            s_valid_x,
   output logic            s_ready_x,
   input  logic            s_valid_f,
   output logic            s_ready_f,
   output logic            m_valid_y,
   input  logic            m_ready_y,
   output logic [LOGN-1:0] addr_x,
   output logic            wr_en_x,
   output logic [LOGM-1:0] addr_f,
   output logic            wr_en_f,
   output logic            clr_acc,
   output logic            en_acc
);

   if (M > N || (M % LANES) != 0) begin : g_bad_params
      $error("conv_seq_ctrl: need M <= N and M a multiple of LANES");
   end

   conv_state_t     state, state_nxt;
   logic [LOGN-1:0] out_idx, out_idx_nxt;
   logic [LOGM:0]   tap, tap_nxt;
   logic [LOGN:0]   x_cnt;
   logic [LOGM:0]   f_cnt;
   logic [LOGN:0]   addr_sum;
   logic            in_load, x_rdy, f_rdy, x_full, f_full;
   logic            x_done, f_done, last_tap, last_out, clear_cnt;

   assign in_load   = (state == LOAD);
   assign s_ready_x = x_rdy & in_load;
   assign s_ready_f = f_rdy & in_load;
   assign clear_cnt = (state == OUT) & m_ready_y & last_out & ~reset;

   load_cnt #(.SIZE(N), .LOGSIZE(LOGN)) u_load_x (
      .clk   (clk),
      .reset (reset),
      .valid (s_valid_x & in_load),
      .ready (x_rdy),
      .wr_en (wr_en_x),
      .cnt   (x_cnt),
      .full  (x_full),
      .clear (clear_cnt)
   );

   load_cnt #(.SIZE(M), .LOGSIZE(LOGM)) u_load_f (
      .clk   (clk),
      .reset (reset),
      .valid (s_valid_f & in_load),
      .ready (f_rdy),
      .wr_en (wr_en_f),
      .cnt   (f_cnt),
      .full  (f_full),
      .clear (clear_cnt)
   );

   // Look ahead at the accepting write so ISSUE starts on the very next cycle.
   assign x_done   = x_full | (wr_en_x & (x_cnt == (LOGN+1)'(N-1)));
   assign f_done   = f_full | (wr_en_f & (f_cnt == (LOGM+1)'(M-1)));
   assign last_tap = (tap == (LOGM+1)'(M-LANES));
   assign last_out = (out_idx == LOGN'(N-M));
   assign addr_sum = (LOGN+1)'(out_idx) + (LOGN+1)'(tap);

   always_comb begin
      state_nxt   = state;
      out_idx_nxt = out_idx;
      tap_nxt     = tap;
      clr_acc     = 1'b0;
      m_valid_y   = 1'b0;
      addr_x      = x_cnt[LOGN-1:0];
      addr_f      = f_cnt[LOGM-1:0];
      case (state)
         LOAD: begin
            if (x_done && f_done) begin
               state_nxt   = ISSUE;
               out_idx_nxt = '0;
               tap_nxt     = '0;
            end
         end
         ISSUE: begin
            addr_x  = addr_sum[LOGN-1:0];
            addr_f  = tap[LOGM-1:0];
            clr_acc = (tap == '0);
            tap_nxt = tap + (LOGM+1)'(LANES);
            if (last_tap) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            addr_x    = out_idx;
            addr_f    = '0;
            state_nxt = OUT;
         end
         OUT: begin
            addr_x    = out_idx;
            addr_f    = '0;
            m_valid_y = 1'b1;
            if (m_ready_y) begin
               tap_nxt = '0;
               if (last_out) begin
                  state_nxt   = LOAD;
                  out_idx_nxt = '0;
               end else begin
                  state_nxt   = ISSUE;
                  out_idx_nxt = out_idx + LOGN'(1);
               end
            end
         end
         default: state_nxt = LOAD;
      endcase
      if (reset) begin
         clr_acc   = 1'b0;
         m_valid_y = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= LOAD;
         out_idx <= '0;
         tap     <= '0;
         en_acc  <= 1'b0;
      end else begin
         state   <= state_nxt;
         out_idx <= out_idx_nxt;
         tap     <= tap_nxt;
         en_acc  <= (state == ISSUE);
      end
   end

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Bench for conv_seq_ctrl: behavioural datapath model plus scoreboard of reference convolutions.
module tb_conv_seq_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUT A: default parameters ----------------
   logic reset, s_valid_x, s_valid_f, m_ready_y;
   logic s_ready_x, s_ready_f, m_valid_y, wr_en_x, wr_en_f, clr_acc, en_acc;
   logic [2:0] addr_x;
   logic [1:0] addr_f;
   logic signed [7:0] x_data, f_data;

   conv_seq_ctrl u_dut_a (
      .clk(clk), .reset(reset),
      .s_valid_x(s_valid_x), .s_ready_x(s_ready_x),
      .s_valid_f(s_valid_f), .s_ready_f(s_ready_f),
      .m_valid_y(m_valid_y), .m_ready_y(m_ready_y),
      .addr_x(addr_x), .wr_en_x(wr_en_x),
      .addr_f(addr_f), .wr_en_f(wr_en_f),
      .clr_acc(clr_acc), .en_acc(en_acc)
   );

   logic signed [7:0] xm_a [8];
   logic signed [7:0] fm_a [4];
   int lane_a, lane_q_a, acc_a, ix_a, jf_a;

   always_comb begin
      lane_a = 0;
      ix_a = 0;
      jf_a = 0;
      for (int l = 0; l < 4; l++) begin
         ix_a = int'(addr_x) + l;
         jf_a = int'(addr_f) + l;
         if (ix_a < 8 && jf_a < 4) lane_a = lane_a + int'(xm_a[ix_a[2:0]]) * int'(fm_a[jf_a[1:0]]);
      end
   end

   always @(posedge clk) begin
      if (wr_en_x) xm_a[addr_x] <= x_data;
      if (wr_en_f) fm_a[addr_f] <= f_data;
      lane_q_a <= lane_a;
      if (clr_acc) acc_a <= 0;
      else if (en_acc) acc_a <= acc_a + lane_q_a;
   end

   // ---------------- DUT B: N=16, M=8 ----------------
   logic b_reset, b_s_valid_x, b_s_valid_f, b_m_ready_y;
   logic b_s_ready_x, b_s_ready_f, b_m_valid_y, b_wr_en_x, b_wr_en_f, b_clr_acc, b_en_acc;
   logic [3:0] b_addr_x;
   logic [2:0] b_addr_f;
   logic signed [7:0] b_x_data, b_f_data;

   conv_seq_ctrl #(.N(16), .M(8), .LANES(4), .LOGN(4), .LOGM(3)) u_dut_b (
      .clk(clk), .reset(b_reset),
      .s_valid_x(b_s_valid_x), .s_ready_x(b_s_ready_x),
      .s_valid_f(b_s_valid_f), .s_ready_f(b_s_ready_f),
      .m_valid_y(b_m_valid_y), .m_ready_y(b_m_ready_y),
      .addr_x(b_addr_x), .wr_en_x(b_wr_en_x),
      .addr_f(b_addr_f), .wr_en_f(b_wr_en_f),
      .clr_acc(b_clr_acc), .en_acc(b_en_acc)
   );

   logic signed [7:0] xm_b [16];
   logic signed [7:0] fm_b [8];
   int lane_b, lane_q_b, acc_b, ix_b, jf_b;

   always_comb begin
      lane_b = 0;
      ix_b = 0;
      jf_b = 0;
      for (int l = 0; l < 4; l++) begin
         ix_b = int'(b_addr_x) + l;
         jf_b = int'(b_addr_f) + l;
         if (ix_b < 16 && jf_b < 8) lane_b = lane_b + int'(xm_b[ix_b[3:0]]) * int'(fm_b[jf_b[2:0]]);
      end
   end

   always @(posedge clk) begin
      if (b_wr_en_x) xm_b[b_addr_x] <= b_x_data;
      if (b_wr_en_f) fm_b[b_addr_f] <= b_f_data;
      lane_q_b <= lane_b;
      if (b_clr_acc) acc_b <= 0;
      else if (b_en_acc) acc_b <= acc_b + lane_q_b;
   end

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
         $error("%s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   int q_a[$];
   int q_b[$];
   int hs_cyc[$];
   int n_out_a = 0;
   int n_out_b = 0;
   int clr_cnt_b = 0;
   int en_cnt_b = 0;

   always @(negedge clk) begin
      if (!reset && m_valid_y && m_ready_y) begin
         hs_cyc.push_back(cyc);
         n_out_a++;
         if (q_a.size() == 0) chk("sb_a_empty", 0, 1);
         else chk("y_a", acc_a, q_a.pop_front());
      end
   end

   always @(negedge clk) begin
      if (!b_reset) begin
         if (b_clr_acc) clr_cnt_b++;
         if (b_en_acc) en_cnt_b++;
         if (b_m_valid_y && b_m_ready_y) begin
            n_out_b++;
            chk("clr_per_out_b", clr_cnt_b, 1);
            chk("en_per_out_b", en_cnt_b, 2);
            clr_cnt_b = 0;
            en_cnt_b = 0;
            if (q_b.size() == 0) chk("sb_b_empty", 0, 1);
            else chk("y_b", acc_b, q_b.pop_front());
         end
      end
   end

   // ---------------- stimulus ----------------
   int vx[8];
   int vf[4];
   int wx[16];
   int wf[8];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp_a();
      int s;
      for (int o = 0; o < 5; o++) begin
         s = 0;
         for (int j = 0; j < 4; j++) s += vx[o+j] * vf[j];
         q_a.push_back(s);
      end
   endtask

   // x on every cycle; f on cycles off..off+3
   task automatic load_a(input int off);
      push_exp_a();
      for (int i = 0; i < 8; i++) begin
         s_valid_x = 1'b1;
         x_data = 8'(vx[i]);
         s_valid_f = (i >= off && i < off + 4);
         f_data = s_valid_f ? 8'(vf[i-off]) : 8'bx;
         tick();
      end
      s_valid_x = 1'b0;
      s_valid_f = 1'b0;
      x_data = 8'bx;
      f_data = 8'bx;
   endtask

   task automatic wait_outs(input int target);
      for (int t = 0; t < 300 && n_out_a < target; t++) tick();
      tick();
      chk("n_out_a", n_out_a, target);
      chk("valid_after_last", m_valid_y, 0);
      chk("ready_x_after_last", s_ready_x, 1);
   endtask

   task automatic take_one();
      for (int t = 0; t < 50 && !m_valid_y; t++) tick();
      chk("valid_wait", m_valid_y, 1);
      m_ready_y = 1'b1;
      tick();
      m_ready_y = 1'b0;
   endtask

   task automatic rand_vec();
      for (int i = 0; i < 8; i++) vx[i] = int'($urandom_range(255)) - 128;
      for (int i = 0; i < 4; i++) vf[i] = int'($urandom_range(255)) - 128;
   endtask

   initial begin
      int acc;
      reset = 1'b1; s_valid_x = 1'b0; s_valid_f = 1'b0; m_ready_y = 1'b0;
      x_data = 8'bx; f_data = 8'bx;
      b_reset = 1'b1; b_s_valid_x = 1'b0; b_s_valid_f = 1'b0; b_m_ready_y = 1'b0;
      b_x_data = 8'bx; b_f_data = 8'bx;

      // reset state, including combinational gating of ready/write while reset is high
      tick(); tick();
      s_valid_x = 1'b1; s_valid_f = 1'b1;
      #1;
      chk("rst_ready_x", s_ready_x, 0);
      chk("rst_ready_f", s_ready_f, 0);
      chk("rst_wr_x", wr_en_x, 0);
      chk("rst_wr_f", wr_en_f, 0);
      chk("rst_valid_y", m_valid_y, 0);
      chk("rst_en_acc", en_acc, 0);
      chk("rst_clr_acc", clr_acc, 0);
      s_valid_x = 1'b0; s_valid_f = 1'b0;
      tick();
      reset = 1'b0;
      #1;
      chk("ready_x_idle", s_ready_x, 1);
      chk("ready_f_idle", s_ready_f, 1);

      // 1: ramp x, unit filter, streams always valid, sink always ready
      for (int i = 0; i < 8; i++) vx[i] = i + 1;
      for (int i = 0; i < 4; i++) vf[i] = 1;
      m_ready_y = 1'b1;
      n_out_a = 0;
      hs_cyc.delete();
      load_a(0);
      chk("t1_clr_first_issue", clr_acc, 1);
      chk("t1_addr_x_issue", addr_x, 0);
      chk("t1_valid_e1", m_valid_y, 0);
      tick();
      chk("t1_en_drain", en_acc, 1);
      chk("t1_valid_e2", m_valid_y, 0);
      tick();
      chk("t1_valid_rise", m_valid_y, 1);
      wait_outs(5);
      chk("t1_hs_count", hs_cyc.size(), 5);
      for (int i = 0; i + 1 < hs_cyc.size(); i++) chk("t1_spacing", hs_cyc[i+1] - hs_cyc[i], 3);

      // 2: filter first, then x with gaps and X data on idle cycles
      n_out_a = 0;
      push_exp_a();
      s_valid_x = 1'b0;
      for (int i = 0; i < 4; i++) begin
         s_valid_f = 1'b1;
         f_data = 8'(vf[i]);
         #1;
         chk("t2_wr_f", wr_en_f, 1);
         chk("t2_addr_f", addr_f, i);
         tick();
      end
      f_data = 8'bx;
      acc = 0;
      for (int i = 0; i < 40 && acc < 8; i++) begin
         s_valid_x = ((i % 2) == 0);
         x_data = s_valid_x ? 8'(vx[acc]) : 8'bx;
         #1;
         chk("t2_wr_x", wr_en_x, s_valid_x);
         chk("t2_ready_f_full", s_ready_f, 0);
         if (s_valid_x) begin
            chk("t2_addr_x", addr_x, acc);
            acc++;
         end
         tick();
      end
      s_valid_x = 1'b0; s_valid_f = 1'b0; x_data = 8'bx;
      chk("t2_x_accepted", acc, 8);
      wait_outs(5);

      // 3: downstream stall on output 2
      rand_vec();
      n_out_a = 0;
      m_ready_y = 1'b0;
      load_a(0);
      take_one();
      for (int t = 0; t < 50 && !m_valid_y; t++) tick();
      for (int t = 0; t < 10; t++) begin
         chk("t3_hold_valid", m_valid_y, 1);
         chk("t3_hold_en", en_acc, 0);
         chk("t3_hold_addr", addr_x, 1);
         tick();
      end
      m_ready_y = 1'b1;
      tick();
      chk("t3_reissue_clr", clr_acc, 1);
      chk("t3_reissue_addr", addr_x, 2);
      chk("t3_reissue_valid", m_valid_y, 0);
      wait_outs(5);

      // 4: final x and final f accepted on the same edge
      rand_vec();
      n_out_a = 0;
      load_a(4);
      chk("t4_clr", clr_acc, 1);
      chk("t4_addr_x", addr_x, 0);
      chk("t4_addr_f", addr_f, 0);
      chk("t4_ready_x_off", s_ready_x, 0);
      tick();
      chk("t4_clr_once", clr_acc, 0);
      chk("t4_en", en_acc, 1);
      wait_outs(5);

      // 5: reset while presenting output 3, then a fresh extreme vector
      rand_vec();
      n_out_a = 0;
      m_ready_y = 1'b0;
      load_a(0);
      take_one();
      take_one();
      for (int t = 0; t < 50 && !m_valid_y; t++) tick();
      chk("t5_in_out", m_valid_y, 1);
      reset = 1'b1;
      q_a.delete();
      tick();
      reset = 1'b0;
      #1;
      chk("t5_valid_dropped", m_valid_y, 0);
      chk("t5_ready_x", s_ready_x, 1);
      chk("t5_ready_f", s_ready_f, 1);
      for (int i = 0; i < 8; i++) vx[i] = -128;
      for (int i = 0; i < 4; i++) vf[i] = 127;
      n_out_a = 0;
      m_ready_y = 1'b1;
      load_a(0);
      wait_outs(5);
      chk("t5_ref_value", -128 * 127 * 4, -65024);

      // 6: N=16, M=8 instance
      b_reset = 1'b0;
      #1;
      chk("b_ready_x", b_s_ready_x, 1);
      chk("b_ready_f", b_s_ready_f, 1);
      for (int i = 0; i < 16; i++) wx[i] = int'($urandom_range(255)) - 128;
      for (int i = 0; i < 8; i++) wf[i] = int'($urandom_range(255)) - 128;
      for (int o = 0; o < 9; o++) begin
         acc = 0;
         for (int j = 0; j < 8; j++) acc += wx[o+j] * wf[j];
         q_b.push_back(acc);
      end
      b_m_ready_y = 1'b1;
      for (int i = 0; i < 16; i++) begin
         b_s_valid_x = 1'b1;
         b_x_data = 8'(wx[i]);
         b_s_valid_f = (i < 8);
         b_f_data = (i < 8) ? 8'(wf[i]) : 8'bx;
         tick();
      end
      b_s_valid_x = 1'b0; b_s_valid_f = 1'b0;
      for (int t = 0; t < 400 && n_out_b < 9; t++) tick();
      tick();
      chk("n_out_b", n_out_b, 9);
      chk("b_valid_after_last", b_m_valid_y, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
